// File: rtl/riscv_pkg.sv
// Shared types for the EX-stage forwarding / load-use hazard control.
package riscv_pkg;

  // Register-index width of the RV32I register file (x0..x31).
  localparam int REG_ADDR_W_DEFAULT = 5;

  // Operand select driven to the EX-stage forwarding muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register-file read value
    FWD_WB  = 2'b01,  // MEM/WB writeback data
    FWD_MEM = 2'b10   // EX/MEM ALU result
  } fwd_sel_e;

  // Destination info carried down the shadow pipeline.
  typedef struct packed {
    logic                          valid;
    logic [REG_ADDR_W_DEFAULT-1:0] rd;
    logic                          reg_write;
    logic                          mem_read;
  } hz_stage_t;

  // True when a stage will write a non-x0 register that matches src.
  function automatic logic stage_hits(input hz_stage_t stg,
                                      input logic [REG_ADDR_W_DEFAULT-1:0] src);
    return stg.valid & stg.reg_write & (stg.rd != '0) & (stg.rd == src);
  endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One shadow pipeline stage of destination info; valid drops on reset.
module hz_stage_reg
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  hz_stage_t i_d,
  output hz_stage_t o_q
);

  hz_stage_t r_q;

  // Advance every cycle; reset empties the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall control for the RV32I EX stage.
// Tracks EX/MEM/WB destinations in a shadow pipeline fed from decode.
module fwd_hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,  // must match the package width
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush_ex,
  output logic [1:0]            mux_sel_forward_A,
  output logic [1:0]            mux_sel_forward_B,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int                NUM_STG = 3;  // 0 = EX, 1 = MEM, 2 = WB
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_stage_t             w_stg_d [NUM_STG];
  hz_stage_t             w_stg_q [NUM_STG];
  logic [REG_ADDR_W-1:0] r_ex_rs1;
  logic [REG_ADDR_W-1:0] r_ex_rs2;
  logic                  r_ex_use1;
  logic                  r_ex_use2;
  logic [CNT_W-1:0]      r_stall_count;
  logic                  w_load_use;
  logic                  w_stall;
  logic                  w_unused_wb_mr;

  // Operand select for the EX instruction; the younger MEM writer wins over WB.
  function automatic fwd_sel_e fwd_select(input logic                  ex_valid,
                                          input logic                  use_src,
                                          input logic [REG_ADDR_W-1:0] src,
                                          input hz_stage_t             mem,
                                          input hz_stage_t             wb);
    if (ex_valid & use_src & stage_hits(mem, src)) return FWD_MEM;
    if (ex_valid & use_src & stage_hits(wb, src))  return FWD_WB;
    return FWD_RF;
  endfunction

  // Decode feeds EX; a bubble or a flush kills the entering instruction.
  always_comb begin
    w_stg_d[0]           = '0;
    w_stg_d[0].valid     = id_valid & ~w_stall & ~flush_ex;
    w_stg_d[0].rd        = id_rd;
    w_stg_d[0].reg_write = id_reg_write;
    w_stg_d[0].mem_read  = id_mem_read;
  end

  // Shadow stages: EX, then MEM <= EX, WB <= MEM.
  generate
    for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_stage
      if (gi > 0) begin : g_chain
        assign w_stg_d[gi] = w_stg_q[gi-1];
      end
      hz_stage_reg u_stage (
        .clk (clk),
        .rst (rst),
        .i_d (w_stg_d[gi]),
        .o_q (w_stg_q[gi])
      );
    end
  endgenerate

  // Load-or-not is irrelevant once an instruction reaches WB.
  assign w_unused_wb_mr = w_stg_q[2].mem_read;

  // Source fields of the EX instruction, needed only for forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rs1  <= '0;
      r_ex_rs2  <= '0;
      r_ex_use1 <= 1'b0;
      r_ex_use2 <= 1'b0;
    end else begin
      r_ex_rs1  <= id_rs1;
      r_ex_rs2  <= id_rs2;
      r_ex_use1 <= id_use_rs1;
      r_ex_use2 <= id_use_rs2;
    end
  end

  assign mux_sel_forward_A = fwd_select(w_stg_q[0].valid, r_ex_use1, r_ex_rs1,
                                        w_stg_q[1], w_stg_q[2]);
  assign mux_sel_forward_B = fwd_select(w_stg_q[0].valid, r_ex_use2, r_ex_rs2,
                                        w_stg_q[1], w_stg_q[2]);

  // A load in EX whose result the ID instruction needs costs one bubble.
  assign w_load_use = id_valid & w_stg_q[0].valid & w_stg_q[0].mem_read &
                      (w_stg_q[0].rd != '0) &
                      ((id_use_rs1 & (id_rs1 == w_stg_q[0].rd)) |
                       (id_use_rs2 & (id_rs2 == w_stg_q[0].rd)));
  assign w_stall    = w_load_use & ~flush_ex;

  assign stall_if  = w_stall;
  assign stall_id  = w_stall;
  assign bubble_ex = w_stall;

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_ONE;
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: instruction-sequence table plus
// hand-written async-reset and counter-saturation sequences.
module tb_fwd_hazard_unit;

  localparam int RW  = 5;
  localparam int CW  = 4;  // narrow counter so saturation is reachable

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic          flush_ex;
  logic [1:0]    sel_a, sel_b;
  logic          stall_if, stall_id, bubble_ex;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  fwd_hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .id_rd             (id_rd),
    .id_reg_write      (id_reg_write),
    .id_mem_read       (id_mem_read),
    .flush_ex          (flush_ex),
    .mux_sel_forward_A (sel_a),
    .mux_sel_forward_B (sel_b),
    .stall_if          (stall_if),
    .stall_id          (stall_id),
    .bubble_ex         (bubble_ex),
    .stall_count       (stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          v;
    logic [RW-1:0] rs1, rs2;
    logic          u1, u2;
    logic [RW-1:0] rd;
    logic          rw, mr, fl;
    logic [1:0]    ea, eb;
    logic          es;
    logic [CW-1:0] ec;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic v, input int rs1, input int rs2,
                              input logic u1, input logic u2, input int rd,
                              input logic rw, input logic mr, input logic fl,
                              input logic [1:0] ea, input logic [1:0] eb,
                              input logic es, input int ec);
    vec_t t;
    t.v = v;  t.rs1 = RW'(rs1); t.rs2 = RW'(rs2);
    t.u1 = u1; t.u2 = u2; t.rd = RW'(rd);
    t.rw = rw; t.mr = mr; t.fl = fl;
    t.ea = ea; t.eb = eb; t.es = es; t.ec = CW'(ec);
    return t;
  endfunction

  task automatic drive(input logic v, input int rs1, input int rs2,
                       input logic u1, input logic u2, input int rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v;  id_rs1 = RW'(rs1); id_rs2 = RW'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = RW'(rd);
    id_reg_write = rw; id_mem_read = mr; flush_ex = fl;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stall(input string name, input logic exp);
    check({name, ".stall_if"},  32'(stall_if),  32'(exp));
    check({name, ".stall_id"},  32'(stall_id),  32'(exp));
    check({name, ".bubble_ex"}, 32'(bubble_ex), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Instruction sequence: {v,rs1,rs2,u1,u2,rd,rw,mr,flush} -> {A,B,stall,count}
    tbl[0]  = mk(1,1,2,1,1,5,1,0,0, 2'b00,2'b00,0,0); // add x5,x1,x2
    tbl[1]  = mk(1,5,3,1,1,6,1,0,0, 2'b00,2'b00,0,0); // sub x6,x5,x3
    tbl[2]  = mk(0,0,0,0,0,0,0,0,0, 2'b10,2'b00,0,0); // sub in EX: A from EX/MEM
    tbl[3]  = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,0,0);
    tbl[4]  = mk(1,1,2,1,1,5,1,0,0, 2'b00,2'b00,0,0); // add x5
    tbl[5]  = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,0,0); // nop
    tbl[6]  = mk(1,4,5,1,1,7,1,0,0, 2'b00,2'b00,0,0); // or x7,x4,x5
    tbl[7]  = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b01,0,0); // or in EX: B from WB
    tbl[8]  = mk(1,1,2,1,1,5,1,0,0, 2'b00,2'b00,0,0); // add x5
    tbl[9]  = mk(1,1,2,1,1,5,1,0,0, 2'b00,2'b00,0,0); // add x5
    tbl[10] = mk(1,4,5,1,1,7,1,0,0, 2'b00,2'b00,0,0); // or x7,x4,x5
    tbl[11] = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b10,0,0); // two writers: MEM wins
    tbl[12] = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,0,0);
    tbl[13] = mk(1,1,0,1,0,8,1,1,0, 2'b00,2'b00,0,0); // lw x8,0(x1)
    tbl[14] = mk(1,8,8,1,1,9,1,0,0, 2'b00,2'b00,1,0); // add x9,x8,x8: stall
    tbl[15] = mk(1,8,8,1,1,9,1,0,0, 2'b00,2'b00,0,1); // held add, bubble in EX
    tbl[16] = mk(0,0,0,0,0,0,0,0,0, 2'b01,2'b01,0,1); // add in EX: both from WB
    tbl[17] = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,0,1);
    tbl[18] = mk(1,1,0,1,0,0,1,1,0, 2'b00,2'b00,0,1); // lw x0,0(x1)
    tbl[19] = mk(1,0,0,1,1,9,1,0,0, 2'b00,2'b00,0,1); // add x9,x0,x0: no stall
    tbl[20] = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,0,1); // no forward from x0
    tbl[21] = mk(1,1,0,1,0,0,1,0,0, 2'b00,2'b00,0,1); // addi x0,x1,1
    tbl[22] = mk(1,0,0,1,1,10,1,0,0,2'b00,2'b00,0,1); // add x10,x0,x0
    tbl[23] = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,0,1); // x0 writer in MEM ignored
    tbl[24] = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,0,1);
    tbl[25] = mk(1,1,0,1,0,8,1,1,0, 2'b00,2'b00,0,1); // lw x8
    tbl[26] = mk(1,8,8,1,1,9,1,0,1, 2'b00,2'b00,0,1); // hazard + flush: no stall
    tbl[27] = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,0,1); // flushed add is invalid
    tbl[28] = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,0,1);

    rst = 1'b1;
    drive(0,0,0,0,0,0,0,0,0);
    @(negedge clk);
    check("reset.sel_a", 32'(sel_a), 32'h0);
    check("reset.sel_b", 32'(sel_b), 32'h0);
    check_stall("reset", 1'b0);
    check("reset.count", 32'(stall_count), 32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, int'(tbl[i].rs1), int'(tbl[i].rs2), tbl[i].u1, tbl[i].u2,
            int'(tbl[i].rd), tbl[i].rw, tbl[i].mr, tbl[i].fl);
      @(negedge clk);
      $display("vec %0d: A=%b B=%b stall=%b/%b/%b count=%0d", i, sel_a, sel_b,
               stall_if, stall_id, bubble_ex, stall_count);
      check($sformatf("vec%0d.sel_a", i), 32'(sel_a), 32'(tbl[i].ea));
      check($sformatf("vec%0d.sel_b", i), 32'(sel_b), 32'(tbl[i].eb));
      check_stall($sformatf("vec%0d", i), tbl[i].es);
      check($sformatf("vec%0d.count", i), 32'(stall_count), 32'(tbl[i].ec));
      tick();
    end

    // Async reset while a forward is selected: select drops before the next edge.
    drive(1,1,2,1,1,5,1,0,0); tick();           // add x5
    drive(1,5,3,1,1,6,1,0,0); tick();           // sub x6,x5,x3
    drive(0,0,0,0,0,0,0,0,0);
    @(negedge clk);
    check("rstfwd.before", 32'(sel_a), 32'h2);
    #2 rst = 1'b1;
    #1;
    $display("async reset with forward: A=%b B=%b", sel_a, sel_b);
    check("rstfwd.after", 32'(sel_a), 32'h0);
    tick();
    rst = 1'b0;

    // Async reset in the middle of a load-use stall.
    drive(1,1,0,1,0,8,1,1,0); tick();           // lw x8
    drive(1,8,8,1,1,9,1,0,0);                   // add x9,x8,x8
    @(negedge clk);
    check_stall("rststall.before", 1'b1);
    tick();                                     // one stall counted
    drive(1,1,0,1,0,8,1,1,0); tick();           // lw x8 again
    drive(1,8,8,1,1,9,1,0,0);
    @(negedge clk);
    check("rststall.count_before", 32'(stall_count), 32'h1);
    check_stall("rststall.active", 1'b1);
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-stall: stall=%b count=%0d", stall_if, stall_count);
    check_stall("rststall.after", 1'b0);
    check("rststall.count_after", 32'(stall_count), 32'h0);
    #1 rst = 1'b0;
    #1;
    check_stall("rststall.release", 1'b0);      // empty pipeline: no hazard
    tick();
    @(negedge clk);
    check("rststall.count_post", 32'(stall_count), 32'h0);
    tick();

    // Repeated load-use pairs: counter climbs to all-ones and holds.
    for (int i = 1; i <= 17; i++) begin
      int exp_cnt;
      exp_cnt = (i < 15) ? i : 15;
      drive(1,1,0,1,0,8,1,1,0); tick();         // lw x8
      drive(1,8,8,1,1,9,1,0,0);                 // add x9,x8,x8
      @(negedge clk);
      check($sformatf("sat%0d.stall", i), 32'(stall_if), 32'h1);
      tick();
      @(negedge clk);
      $display("sat %0d: stall=%b count=%0d", i, stall_if, stall_count);
      check($sformatf("sat%0d.nostall", i), 32'(stall_if), 32'h0);
      check($sformatf("sat%0d.count", i), 32'(stall_count), 32'(exp_cnt));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
